keypad_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad and debounces key presses.
- Each accepted key's 4-bit hex code is shifted into a 16-bit entry register.
- This is the input-side counterpart of the multiplexed hex display: the display drives grid/segment lines out, this block drives row lines out and reads column lines back.
- value_o feeds the adder datapath in place of, or alongside, sw_s.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_scanner_col_sync.sv | 34 +++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// A column pattern is "valid" only when exactly one column line is pulled low.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_t;

    // Multi-low patterns (ghosting, two keys in one row) are reported as invalid.
    function automatic onehot_t onehot_low_idx(input logic [3:0] col);
        onehot_t r;
        r.valid = 1'b0;
        r.idx   = 2'd0;
        case (col)
            4'b1110: begin r.valid = 1'b1; r.idx = 2'd0; end
            4'b1101: begin r.valid = 1'b1; r.idx = 2'd1; end
            4'b1011: begin r.valid = 1'b1; r.idx = 2'd2; end
            4'b0111: begin r.valid = 1'b1; r.idx = 2'd3; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
// Resets to all-high so a reset never looks like a key press.
module col_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] meta_d;
    logic [3:0] sync_q;
    logic [3:0] sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= ROW_IDLE;
            sync_q <= ROW_IDLE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row drive, debounce FSM and a 16-bit
// hex entry register that shifts in each accepted key code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_i,
    input  logic        clear_i,
    output logic [3:0]  row_o,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] value_o,
    output state_e      dbg_state_o
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_SCANS);

    logic [3:0]    col_s;
    onehot_t       hit;
    logic          sample;
    logic          accept;
    logic [3:0]    new_code;
    logic [3:0]    latched_pat;

    state_e        state_q,     state_d;
    logic [1:0]    row_idx_q,   row_idx_d;
    logic [1:0]    col_idx_q,   col_idx_d;
    logic [DW-1:0] dwell_q,     dwell_d;
    logic [MW-1:0] match_q,     match_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic [15:0]   value_q,     value_d;
    logic [3:0]    row_q,       row_d;

    col_sync u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (col_i),
        .q_o   (col_s)
    );

    assign hit         = onehot_low_idx(col_s);
    assign sample      = (dwell_q == DWELL_LAST);
    assign latched_pat = ROW_IDLE ^ (4'b0001 << col_idx_q);

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        match_d     = match_q;
        key_code_d  = key_code_q;
        value_d     = value_q;
        key_valid_d = 1'b0;
        accept      = 1'b0;
        new_code    = {row_idx_q, col_idx_q};
        dwell_d     = sample ? '0 : dwell_q + 1'b1;

        // Columns are only trusted at the end of a dwell, once the synchroniser
        // has settled on the currently driven row.
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (hit.valid) begin
                        col_idx_d = hit.idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            match_d = MW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == latched_pat) begin
                        if (match_q + MW'(1) == MATCH_DONE) begin
                            accept = 1'b1;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d   = '0;
                        state_d   = SCAN;
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
                HELD: begin
                    if (col_s == ROW_IDLE) begin
                        if (match_q + MW'(1) == MATCH_DONE) begin
                            match_d   = '0;
                            state_d   = SCAN;
                            row_idx_d = row_idx_q + 1'b1;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                default: begin
                    match_d = '0;
                    state_d = SCAN;
                end
            endcase
        end

        if (accept) begin
            new_code    = {row_idx_q, col_idx_d};
            key_valid_d = 1'b1;
            key_code_d  = new_code;
            value_d     = {value_q[11:0], new_code};
            match_d     = '0;
            state_d     = HELD;
        end

        if (clear_i) begin
            value_d = '0;
        end

        row_d = ROW_IDLE ^ (4'b0001 << row_idx_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            match_q     <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            value_q     <= 16'd0;
            row_q       <= 4'b1110;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            match_q     <= match_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            value_q     <= value_d;
            row_q       <= row_d;
        end
    end

    assign row_o       = row_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign value_o     = value_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a behavioural 4x4 keypad matrix and a scoreboard
// of expected {key_code, value_o} pairs checked on every key_valid pulse.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        clear_i = 1'b0;
    logic [3:0]  col_i;
    logic [3:0]  row_o;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value_o;
    state_e      dbg_state;

    logic [15:0] keys       = 16'h0000;
    logic        bounce_en  = 1'b0;
    logic [3:0]  bounce_val = 4'hF;

    int          total   = 0;
    int          bad     = 0;
    int          n_valid = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    logic [15:0] exp_value = 16'h0000;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_i       (col_i),
        .clear_i     (clear_i),
        .row_o       (row_o),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .value_o     (value_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- keypad matrix model ----------------
    always_comb begin
        col_i = 4'hF;
        if (bounce_en) begin
            col_i = bounce_val;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            n_valid++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_key_valid got code=%h value=%h expected no pulse", key_code, value_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({key_code, value_o} !== mon_exp) begin
                    bad++;
                    $display("FAIL key_accept got code=%h value=%h expected code=%h value=%h",
                             key_code, value_o, mon_exp[19:16], mon_exp[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press_key(input int r, input int c);
        logic [3:0] code;
        code = 4'(r*4 + c);
        keys[r*4+c] = 1'b1;
        exp_value = {exp_value[11:0], code};
        exp_q.push_back({code, exp_value});
    endtask

    task automatic wait_state(input state_e target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (dbg_state == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int bound, output bit ok);
        ok = (exp_q.size() == 0);
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [3:0] exp_row;
        reset = 1'b0;
        keys  = 16'h0000;
        exp_value = 16'h0000;
        repeat (5) @(negedge clk);
        total++;
        if (row_o !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 ||
            value_o !== 16'h0000 || dbg_state !== SCAN) begin
            bad++;
            $display("FAIL reset_values got row=%b kv=%b code=%h value=%h state=%0d expected row=1110 kv=0 code=0 value=0000 state=0",
                     row_o, key_valid, key_code, value_o, dbg_state);
        end
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_row = 4'hF ^ (4'b0001 << ((k / SCAN_DIV) % 4));
            total++;
            if (row_o !== exp_row) begin
                bad++;
                $display("FAIL idle_row k=%0d got %b expected %b", k, row_o, exp_row);
            end
        end
        total++;
        if (value_o !== 16'h0000 || n_valid != 0) begin
            bad++;
            $display("FAIL idle_quiet got value=%h pulses=%0d expected value=0000 pulses=0", value_o, n_valid);
        end
    endtask

    task automatic test_single_key;
        bit ok;
        int lat;
        int v0;
        v0 = n_valid;
        press_key(2, 1);
        wait_state(DEBOUNCE, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_detect got state=%0d expected DEBOUNCE within 100 cycles", dbg_state);
        end
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (key_valid === 1'b1) break;
        end
        total++;
        if (lat != SCAN_DIV * (DEBOUNCE_SCANS - 1)) begin
            bad++;
            $display("FAIL single_latency got %0d cycles expected %0d", lat, SCAN_DIV * (DEBOUNCE_SCANS - 1));
        end
        total++;
        if (key_code !== 4'h9 || value_o !== 16'h0009) begin
            bad++;
            $display("FAIL single_outputs got code=%h value=%h expected code=9 value=0009", key_code, value_o);
        end
        repeat (40) @(negedge clk);
        total++;
        if (n_valid - v0 != 1) begin
            bad++;
            $display("FAIL single_pulse_count got %0d expected 1", n_valid - v0);
        end
        keys = 16'h0000;
        wait_state(SCAN, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_release got state=%0d expected SCAN", dbg_state);
        end
    endtask

    task automatic test_entry_sequence;
        bit ok;
        for (int i = 1; i <= 5; i++) begin
            press_key(i / 4, i % 4);
            wait_drain(200, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL entry_drain digit=%0d got pending=%0d expected 0", i, exp_q.size());
            end
            if (i == 4) begin
                total++;
                if (value_o !== 16'h1234) begin
                    bad++;
                    $display("FAIL entry_four got %h expected 1234", value_o);
                end
            end
            if (i == 5) begin
                total++;
                if (value_o !== 16'h2345) begin
                    bad++;
                    $display("FAIL entry_overflow got %h expected 2345", value_o);
                end
            end
            keys = 16'h0000;
            wait_state(SCAN, 100, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL entry_release digit=%0d got state=%0d expected SCAN", i, dbg_state);
            end
        end
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        exp_value = 16'h0000;
        total++;
        if (value_o !== 16'h0000) begin
            bad++;
            $display("FAIL entry_clear got %h expected 0000", value_o);
        end
    endtask

    task automatic test_bounce_rejection;
        bit ok;
        int v0;
        logic [3:0] rec;
        v0 = n_valid;
        bounce_en = 1'b1;
        for (int it = 0; it < 3; it++) begin
            bounce_val = 4'b1101;
            wait_state(DEBOUNCE, 100, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL bounce_detect it=%0d got state=%0d expected DEBOUNCE", it, dbg_state);
            end
            rec = row_o;
            bounce_val = 4'b1111;
            repeat (SCAN_DIV) @(negedge clk);
            total++;
            if (dbg_state !== SCAN || row_o !== {rec[2:0], rec[3]}) begin
                bad++;
                $display("FAIL bounce_abort it=%0d got state=%0d row=%b expected state=0 row=%b",
                         it, dbg_state, row_o, {rec[2:0], rec[3]});
            end
        end
        bounce_en = 1'b0;
        repeat (2 * SCAN_DIV) @(negedge clk);
        total++;
        if (n_valid != v0) begin
            bad++;
            $display("FAIL bounce_no_pulse got %0d pulses expected 0", n_valid - v0);
        end
    endtask

    task automatic test_held_and_ghost;
        bit ok;
        bit left_scan;
        int v0;
        v0 = n_valid;
        press_key(3, 0);
        wait_drain(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL held_drain got pending=%0d expected 0", exp_q.size());
        end
        repeat (100 * SCAN_DIV) @(negedge clk);
        total++;
        if (n_valid - v0 != 1) begin
            bad++;
            $display("FAIL held_one_pulse got %0d expected 1", n_valid - v0);
        end
        keys = 16'h0000;
        wait_state(SCAN, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL held_release got state=%0d expected SCAN", dbg_state);
        end
        v0 = n_valid;
        left_scan = 1'b0;
        keys[1*4+0] = 1'b1;
        keys[1*4+2] = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (dbg_state != SCAN) left_scan = 1'b1;
        end
        total++;
        if (left_scan || n_valid != v0) begin
            bad++;
            $display("FAIL ghost_ignored got left_scan=%0d pulses=%0d expected 0 and 0", left_scan, n_valid - v0);
        end
        keys = 16'h0000;
        repeat (4 * SCAN_DIV) @(negedge clk);
    endtask

    task automatic test_reset_collision;
        bit ok;
        int v0;
        keys[1*4+2] = 1'b1;
        wait_state(DEBOUNCE, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstcol_detect got state=%0d expected DEBOUNCE", dbg_state);
        end
        reset = 1'b0;
        #1;
        total++;
        if (row_o !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 ||
            value_o !== 16'h0000 || dbg_state !== SCAN) begin
            bad++;
            $display("FAIL rstcol_async got row=%b kv=%b code=%h value=%h state=%0d expected row=1110 kv=0 code=0 value=0000 state=0",
                     row_o, key_valid, key_code, value_o, dbg_state);
        end
        repeat (3) @(negedge clk);
        exp_value = 16'h0006;
        exp_q.push_back({4'h6, exp_value});
        v0 = n_valid;
        reset = 1'b1;
        wait_drain(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstcol_redetect got pending=%0d expected 0", exp_q.size());
        end
        repeat (20) @(negedge clk);
        total++;
        if (n_valid - v0 != 1) begin
            bad++;
            $display("FAIL rstcol_once got %0d pulses expected 1", n_valid - v0);
        end
        keys = 16'h0000;
        wait_state(SCAN, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstcol_release got state=%0d expected SCAN", dbg_state);
        end
    endtask

    task automatic test_clear_collision;
        bit ok;
        keys[1*4+3] = 1'b1;
        exp_value = 16'h0000;
        exp_q.push_back({4'h7, exp_value});
        wait_state(DEBOUNCE, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL clrcol_detect got state=%0d expected DEBOUNCE", dbg_state);
        end
        repeat (SCAN_DIV - 1) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h7 || value_o !== 16'h0000) begin
            bad++;
            $display("FAIL clrcol_outputs got kv=%b code=%h value=%h expected kv=1 code=7 value=0000",
                     key_valid, key_code, value_o);
        end
        keys = 16'h0000;
        wait_state(SCAN, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL clrcol_release got state=%0d expected SCAN", dbg_state);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_key();
        test_entry_sequence();
        test_bounce_rejection();
        test_held_and_ghost();
        test_reset_collision();
        test_clear_collision();
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty got pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
